// File: rtl/wordline_ctrl_if.sv
// wordline_ctrl_if: request/response bundle for the word-line driver.
//   master modport : requester side (drives req/we/addr, observes status)
//   slave  modport : wordline_ctrl side
//   req, we, addr  : access request, write flag, row address
//   ready, pre, wl, we_out, sense_en, done, err : registered block outputs
interface wordline_ctrl_if #(
  parameter int ADDR_W = 3
);
  localparam int N = 2**ADDR_W;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              pre;
  logic [N-1:0]      wl;
  logic              we_out;
  logic              sense_en;
  logic              done;
  logic              err;

  modport master (
    output req, we, addr,
    input  ready, pre, wl, we_out, sense_en, done, err
  );

  modport slave (
    input  req, we, addr,
    output ready, pre, wl, we_out, sense_en, done, err
  );
endinterface

// File: rtl/wordline_ctrl.sv
// wordline_ctrl: sequential 1-of-2**ADDR_W word-line driver.
// Runs precharge -> word-line assert -> recover for each accepted request and
// drives a registered one-hot word-line vector.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wordline_ctrl_if.slave (req/we/addr in; ready/pre/wl/we_out/
//           sense_en/done/err out). All outputs are direct flop outputs.
// Optional feature macro: WL_ONEHOT_CHECK_EN -- enables the sticky one-hot
// checker on wl (err output + simulation assertion). Undefined: err tied 0.
module wordline_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int PRE_CYCLES = 1,
  parameter int WL_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  wordline_ctrl_if.slave  bus
);
  localparam int N     = 2**ADDR_W;
  localparam int CMAX  = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  generate
    if (PRE_CYCLES < 1 || WL_CYCLES < 1) begin : g_param_chk
      $fatal(1, "wordline_ctrl: PRE_CYCLES and WL_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, PRE, ACT, REC} state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_n;
  logic [ADDR_W-1:0]  r_addr,  w_addr_n;
  logic               r_we,    w_we_n;

  logic               r_ready, w_ready_n;
  logic               r_pre,   w_pre_n;
  logic [N-1:0]       r_wl,    w_wl_n;
  logic               r_we_out, w_we_out_n;
  logic               r_sense, w_sense_n;
  logic               r_done,  w_done_n;

  // State register plus output flops; outputs are precomputed from the next
  // state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_ready  <= 1'b1;
      r_pre    <= 1'b0;
      r_wl     <= '0;
      r_we_out <= 1'b0;
      r_sense  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_addr   <= w_addr_n;
      r_we     <= w_we_n;
      r_ready  <= w_ready_n;
      r_pre    <= w_pre_n;
      r_wl     <= w_wl_n;
      r_we_out <= w_we_out_n;
      r_sense  <= w_sense_n;
      r_done   <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_addr_n  = r_addr;
    w_we_n    = r_we;
    unique case (r_state)
      IDLE: if (bus.req) begin
        w_addr_n  = bus.addr;
        w_we_n    = bus.we;
        w_cnt_n   = CNT_W'(PRE_CYCLES - 1);
        w_state_n = PRE;
      end
      PRE: if (r_cnt == '0) begin
        w_cnt_n   = CNT_W'(WL_CYCLES - 1);
        w_state_n = ACT;
      end else begin
        w_cnt_n   = r_cnt - 1'b1;
      end
      ACT: if (r_cnt == '0) begin
        w_state_n = REC;
      end else begin
        w_cnt_n   = r_cnt - 1'b1;
      end
      REC:     w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase

    w_ready_n  = (w_state_n == IDLE);
    w_pre_n    = (w_state_n == PRE);
    w_wl_n     = '0;
    if (w_state_n == ACT) w_wl_n[w_addr_n] = 1'b1;
    w_we_out_n = (w_state_n == ACT) && w_we_n;
    // Read strobe only in the last ACT cycle, when the cell has settled.
    w_sense_n  = (w_state_n == ACT) && !w_we_n && (w_cnt_n == '0);
    w_done_n   = (w_state_n == REC);
  end

  assign bus.ready    = r_ready;
  assign bus.pre      = r_pre;
  assign bus.wl       = r_wl;
  assign bus.we_out   = r_we_out;
  assign bus.sense_en = r_sense;
  assign bus.done     = r_done;

`ifdef WL_ONEHOT_CHECK_EN
  logic r_err;
  logic w_viol;

  // Any multi-hot wl, or a word line raised outside ACT, is a violation.
  assign w_viol = ($countones(r_wl) > 1) || ((r_wl != '0) && (r_state != ACT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err | w_viol;
  end

  assign bus.err = r_err;

  a_wl_onehot: assert property (@(posedge clk) disable iff (!rst_n) !w_viol)
    else $error("wordline_ctrl: wl one-hot violation");
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_wordline_ctrl.sv
module tb_wordline_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wordline_ctrl_if #(.ADDR_W(3)) bus();

  wordline_ctrl #(.ADDR_W(3), .PRE_CYCLES(1), .WL_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       rst_n;
    logic       req;
    logic       we;
    logic [2:0] addr;
    logic       ready;
    logic       pre;
    logic [7:0] wl;
    logic       we_out;
    logic       sense;
    logic       done;
  } vec_t;

  localparam int NV = 25;
  vec_t vt[NV];

  function automatic vec_t mk(logic r, logic q, logic w, logic [2:0] a,
                              logic rdy, logic p, logic [7:0] l, logic wo,
                              logic s, logic d);
    vec_t v;
    v.rst_n = r; v.req = q; v.we = w; v.addr = a;
    v.ready = rdy; v.pre = p; v.wl = l; v.we_out = wo; v.sense = s; v.done = d;
    return v;
  endfunction

  task automatic check_outs(string name, logic rdy, logic p, logic [7:0] l,
                            logic wo, logic s, logic d, logic e);
    n_chk++;
    if (bus.ready !== rdy || bus.pre !== p || bus.wl !== l || bus.we_out !== wo ||
        bus.sense_en !== s || bus.done !== d || bus.err !== e) begin
      n_err++;
      $display("FAIL %s: got rdy=%b pre=%b wl=%h we_out=%b sense=%b done=%b err=%b, want rdy=%b pre=%b wl=%h we_out=%b sense=%b done=%b err=%b",
               name, bus.ready, bus.pre, bus.wl, bus.we_out, bus.sense_en, bus.done, bus.err,
               rdy, p, l, wo, s, d, e);
    end
  endtask

  initial begin
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 3'd5;

    //            rst req we addr   rdy pre wl     wo s  d
    // reset held 3 cycles with active-looking inputs
    vt[0]  = mk(0, 1, 1, 3'd5,   1, 0, 8'h00, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 3'd2,   1, 0, 8'h00, 0, 0, 0);
    vt[2]  = mk(0, 0, 1, 3'd7,   1, 0, 8'h00, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 3'd0,   1, 0, 8'h00, 0, 0, 0);
    // read addr=5; addr/we changes after acceptance must be ignored
    vt[4]  = mk(1, 1, 0, 3'd5,   0, 1, 8'h00, 0, 0, 0);
    vt[5]  = mk(1, 0, 1, 3'd2,   0, 0, 8'h20, 0, 0, 0);
    vt[6]  = mk(1, 0, 1, 3'd2,   0, 0, 8'h20, 0, 1, 0);
    vt[7]  = mk(1, 0, 0, 3'd0,   0, 0, 8'h00, 0, 0, 1);
    vt[8]  = mk(1, 0, 0, 3'd0,   1, 0, 8'h00, 0, 0, 0);
    // write addr=0 then addr=7 at minimum spacing (req during REC ignored)
    vt[9]  = mk(1, 1, 1, 3'd0,   0, 1, 8'h00, 0, 0, 0);
    vt[10] = mk(1, 0, 0, 3'd3,   0, 0, 8'h01, 1, 0, 0);
    vt[11] = mk(1, 0, 0, 3'd3,   0, 0, 8'h01, 1, 0, 0);
    vt[12] = mk(1, 0, 0, 3'd3,   0, 0, 8'h00, 0, 0, 1);
    vt[13] = mk(1, 1, 1, 3'd7,   1, 0, 8'h00, 0, 0, 0);
    vt[14] = mk(1, 1, 1, 3'd7,   0, 1, 8'h00, 0, 0, 0);
    vt[15] = mk(1, 0, 0, 3'd1,   0, 0, 8'h80, 1, 0, 0);
    vt[16] = mk(1, 0, 0, 3'd1,   0, 0, 8'h80, 1, 0, 0);
    vt[17] = mk(1, 0, 0, 3'd1,   0, 0, 8'h00, 0, 0, 1);
    vt[18] = mk(1, 0, 0, 3'd1,   1, 0, 8'h00, 0, 0, 0);
    // busy: read addr=6, req addr=3 pulsed during ACT is dropped
    vt[19] = mk(1, 1, 0, 3'd6,   0, 1, 8'h00, 0, 0, 0);
    vt[20] = mk(1, 1, 1, 3'd3,   0, 0, 8'h40, 0, 0, 0);
    vt[21] = mk(1, 1, 1, 3'd3,   0, 0, 8'h40, 0, 1, 0);
    vt[22] = mk(1, 0, 0, 3'd3,   0, 0, 8'h00, 0, 0, 1);
    vt[23] = mk(1, 0, 0, 3'd3,   1, 0, 8'h00, 0, 0, 0);
    vt[24] = mk(1, 0, 0, 3'd3,   1, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n = vt[i].rst_n; bus.req = vt[i].req; bus.we = vt[i].we; bus.addr = vt[i].addr;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vt[i].ready, vt[i].pre, vt[i].wl,
                 vt[i].we_out, vt[i].sense, vt[i].done, 1'b0);
    end

    // async reset mid-ACT of a write to addr=4
    @(negedge clk); bus.req = 1'b1; bus.we = 1'b1; bus.addr = 3'd4;
    @(posedge clk);
    @(negedge clk); bus.req = 1'b0;
    @(posedge clk); #1;
    check_outs("rst_act_pre", 0, 0, 8'h10, 1, 0, 0, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    check_outs("rst_act_async", 1, 0, 8'h00, 0, 0, 0, 1'b0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs("rst_act_idle1", 1, 0, 8'h00, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    check_outs("rst_act_idle2", 1, 0, 8'h00, 0, 0, 0, 1'b0);

`ifdef WL_ONEHOT_CHECK_EN
    // corrupt the word-line flops; err must latch and hold until reset
    @(negedge clk); force dut.r_wl = 8'h03;
    @(posedge clk); #1;
    @(negedge clk); release dut.r_wl;
    @(posedge clk); #1;
    n_chk++;
    if (bus.err !== 1'b1) begin n_err++; $display("FAIL err_set: got %b want 1", bus.err); end
    repeat (2) @(posedge clk); #1;
    n_chk++;
    if (bus.err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", bus.err); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_chk++;
    if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_clr: got %b want 0", bus.err); end
    @(negedge clk); rst_n = 1'b1;
`else
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++;
      if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_tied: got %b want 0", bus.err); end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
